// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the ping-pong frame buffer controller.
package fb_pkg;

    localparam int FB_DEPTH = 320 * 180;
    localparam int FB_ADDR_W = 16;
    localparam logic [15:0] BACKGROUND_COLOR = 16'hFFFF;
    localparam int RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ACCEPT    = 2'd0,
        WAIT_SWAP = 2'd1,
        CLEAR     = 2'd2
    } t_fb_state;

endpackage

// File: rtl/fb_bram_2p.sv
// Simple dual-port block RAM: one write port, one read port, registered read data.
module fb_bram_2p #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 57600,
    parameter int ADDR_W = 16
) (
    input  logic              pixel_clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge pixel_clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame buffer: ray stage fills one bank while video reads the other, 4x upscaled.
// Optional macro FB_CLEAR_EN: wipe the new write bank to BACKGROUND_COLOR after every swap.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int PIXEL_WIDTH        = 16,
    parameter int SCREEN_WIDTH       = 320,
    parameter int SCREEN_HEIGHT      = 180,
    parameter int FULL_SCREEN_WIDTH  = 1280,
    parameter int FULL_SCREEN_HEIGHT = 720,
    parameter int SCALE_SHIFT        = 2
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   ray_valid_in,
    input  logic [15:0]            ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   frame_buff_ready_out,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_active_in,
    input  logic                   new_frame_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   frame_swap_out
);

    localparam int DEPTH = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(DEPTH - 1);

    t_fb_state state_reg, state_next;
    logic wr_sel_reg, wr_sel_next;
    logic last_q_reg;
    logic swap_reg, swap_next;
    logic frame_end;

    logic                   wr_en;
    logic [FB_ADDR_W-1:0]   wr_addr;
    logic [PIXEL_WIDTH-1:0] wr_data;

    logic [FB_ADDR_W-1:0]   rd_addr, rd_addr_reg;
    logic                   rd_in_range;
    logic [RD_LATENCY-1:0]  active_pipe_reg;
    logic [RD_LATENCY-1:0]  sel_pipe_reg;
    logic [PIXEL_WIDTH-1:0] bank_rdata [2];

`ifdef FB_CLEAR_EN
    logic [FB_ADDR_W-1:0] clear_cnt_reg, clear_cnt_next;
`endif

    // Rising-edge qualification so a held last flag closes only one frame.
    assign frame_end = ray_valid_in && ray_last_pixel_in && !last_q_reg;

    always_comb begin
        state_next  = state_reg;
        wr_sel_next = wr_sel_reg;
        swap_next   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = ray_address_in;
        wr_data     = ray_pixel_in;
`ifdef FB_CLEAR_EN
        clear_cnt_next = clear_cnt_reg;
`endif
        case (state_reg)
            ACCEPT: begin
                wr_en = ray_valid_in && (ray_address_in <= LAST_ADDR);
                if (frame_end) begin
                    state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (new_frame_in) begin
                    wr_sel_next = ~wr_sel_reg;
                    swap_next   = 1'b1;
`ifdef FB_CLEAR_EN
                    state_next     = CLEAR;
                    clear_cnt_next = '0;
`else
                    state_next = ACCEPT;
`endif
                end
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clear_cnt_reg;
                wr_data = PIXEL_WIDTH'(BACKGROUND_COLOR);
                if (clear_cnt_reg == LAST_ADDR) begin
                    state_next     = ACCEPT;
                    clear_cnt_next = '0;
                end else begin
                    clear_cnt_next = clear_cnt_reg + 1'b1;
                end
            end
`endif
            default: state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg  <= ACCEPT;
            wr_sel_reg <= 1'b0;
            last_q_reg <= 1'b0;
            swap_reg   <= 1'b0;
`ifdef FB_CLEAR_EN
            clear_cnt_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            wr_sel_reg <= wr_sel_next;
            last_q_reg <= ray_last_pixel_in;
            swap_reg   <= swap_next;
`ifdef FB_CLEAR_EN
            clear_cnt_reg <= clear_cnt_next;
`endif
        end
    end

    assign frame_buff_ready_out = (state_reg == ACCEPT);
    assign frame_swap_out       = swap_reg;

    // 16-bit product is enough for every in-range coordinate; out-of-range ones are masked.
    assign rd_addr = FB_ADDR_W'(16'(vcount_in >> SCALE_SHIFT) * 16'(SCREEN_WIDTH))
                   + FB_ADDR_W'(hcount_in >> SCALE_SHIFT);
    assign rd_in_range = (hcount_in < 11'(FULL_SCREEN_WIDTH))
                      && (vcount_in < 10'(FULL_SCREEN_HEIGHT));

    // Bank select travels with the address so a swap never splits a pixel's read.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_addr_reg     <= '0;
            active_pipe_reg <= '0;
            sel_pipe_reg    <= '0;
        end else begin
            rd_addr_reg     <= rd_addr;
            active_pipe_reg <= {active_pipe_reg[RD_LATENCY-2:0], video_active_in && rd_in_range};
            sel_pipe_reg    <= {sel_pipe_reg[RD_LATENCY-2:0], ~wr_sel_reg};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            fb_bram_2p #(
                .WIDTH  (PIXEL_WIDTH),
                .DEPTH  (DEPTH),
                .ADDR_W (FB_ADDR_W)
            ) u_bram (
                .pixel_clk_in (pixel_clk_in),
                .wr_en        (wr_en && (wr_sel_reg == 1'(gi))),
                .wr_addr      (wr_addr),
                .wr_data      (wr_data),
                .rd_addr      (rd_addr_reg),
                .rd_data      (bank_rdata[gi])
            );
        end
    endgenerate

    assign pixel_out = active_pipe_reg[RD_LATENCY-1]
                     ? bank_rdata[sel_pipe_reg[RD_LATENCY-1]]
                     : '0;

endmodule
